seq_booth_multiplier: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier. It is the clocked successor to the combinational array-multiplier cells.
- Multiplies two WIDTH-bit operands, signed or unsigned as selected per operation. Performs one Booth step per clock.
- Uses a start/ready/done handshake. Sits between operand registers and the datapath result bus.

---
 rtl/mult_pkg.sv | 11 +
 rtl/booth_step.sv | 22 ++
 rtl/seq_booth_multiplier.sv | 84 ++++++++
 tb/tb_seq_booth_multiplier.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the sequential Booth multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    return pair == 2'b10 ? SUB : pair == 2'b01 ? ADD : NOP;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/sub followed by an arithmetic right shift of {acc, b, q}
module booth_step import mult_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_acc,
  input  logic [WIDTH:0]   i_a_ext,
  input  logic [WIDTH:0]   i_b_ext,
  input  logic             i_q,
  output logic [WIDTH+1:0] o_acc,
  output logic [WIDTH:0]   o_b_ext,
  output logic             o_q
);
  booth_op_t        w_op;
  logic [WIDTH+1:0] w_a;
  logic [WIDTH+1:0] w_sum;
  assign w_op    = booth_decode({i_b_ext[0], i_q});
  assign w_a     = {i_a_ext[WIDTH], i_a_ext};
  assign w_sum   = w_op == ADD ? i_acc + w_a : w_op == SUB ? i_acc - w_a : i_acc;
  assign o_acc   = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign o_b_ext = {w_sum[0], i_b_ext[WIDTH:1]};
  assign o_q     = i_b_ext[0];
endmodule

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: sequential radix-2 Booth multiplier, one step per clock, start/ready/done handshake
// Define MULT_EARLY_TERM_EN to finish early once the remaining multiplier bits are all-equal.
module seq_booth_multiplier import mult_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int AW = WIDTH + 2;
  localparam int BW = WIDTH + 1;
  state_t             r_state, w_state_nxt;
  logic [AW-1:0]      r_acc, w_acc_step;
  logic [BW-1:0]      r_a, r_b, w_b_step;
  logic               r_q, w_q_step;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product, w_fin_val;
  logic               w_fin, w_load;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_a_ext (r_a),
    .i_b_ext (r_b),
    .i_q     (r_q),
    .o_acc   (w_acc_step),
    .o_b_ext (w_b_step),
    .o_q     (w_q_step)
  );
`ifdef MULT_EARLY_TERM_EN
  logic [BW-1:0] w_mask;
  logic          w_early;
  // unconsumed multiplier bits sit in the low BW-r_cnt positions of r_b
  assign w_mask    = {BW{1'b1}} >> r_cnt;
  assign w_early   = r_q ? &(r_b | ~w_mask) : ~|(r_b & w_mask);
  assign w_fin     = w_early | (r_cnt == CNT_W'(WIDTH));
  assign w_fin_val = w_early ? (2*WIDTH)'($signed({r_acc, r_b}) >>> (BW - r_cnt))
                             : {w_acc_step[WIDTH-2:0], w_b_step};
`else
  assign w_fin     = r_cnt == CNT_W'(WIDTH);
  assign w_fin_val = {w_acc_step[WIDTH-2:0], w_b_step};
`endif
  assign w_load  = r_state == IDLE && start;
  assign product = r_product;
  always_comb begin
    w_state_nxt = r_state;
    ready       = r_state == IDLE;
    busy        = r_state == CALC;
    done        = r_state == DONE;
    if (w_load) w_state_nxt = CALC;
    else if (r_state == CALC && w_fin) w_state_nxt = DONE;
    else if (r_state == DONE) w_state_nxt = IDLE;
  end
  always_ff @(posedge clock)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clock)
    if (!reset_n) begin
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_q       <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_a   <= {is_signed & a[WIDTH-1], a};
      r_b   <= {is_signed & b[WIDTH-1], b};
      r_acc <= '0;
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_step;
      r_b   <= w_b_step;
      r_q   <= w_q_step;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_fin) r_product <= w_fin_val;
    end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: random and directed checks against an arithmetic model of the multiplier
module tb_seq_booth_multiplier;
  localparam int W = 8;
  logic           clock, reset_n, start, is_signed;
  logic [W-1:0]   a, b;
  logic           ready, busy, done;
  logic [2*W-1:0] product;
  int total = 0, bad = 0;
  bit mon_en = 0;
  logic           m_ready, m_busy, m_done;
  logic [2*W-1:0] m_prod, m_pend;
  int             m_rem;
  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .product(product)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  function automatic logic [2*W-1:0] gold(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint xa, ya, p;
    xa = s ? longint'($signed(x)) : longint'(x);
    ya = s ? longint'($signed(y)) : longint'(y);
    p = xa * ya;
    return p[2*W-1:0];
  endfunction
  // busy cycles between acceptance and done
  function automatic int busy_cycles(input logic s, input logic [W-1:0] y);
`ifdef MULT_EARLY_TERM_EN
    logic [W+1:0] e;
    bit ok;
    e = {s & y[W-1], y, 1'b0};
    for (int k = 0; k <= W; k++) begin
      ok = 1;
      for (int j = k; j <= W + 1; j++) if (e[j] !== e[W+1]) ok = 0;
      if (ok) return k + 1;
    end
`endif
    return W + 1;
  endfunction
  function automatic int lit(input int et, input int def);
`ifdef MULT_EARLY_TERM_EN
    return et;
`else
    return def;
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clock)
    if (!reset_n) begin
      m_ready <= 1; m_busy <= 0; m_done <= 0; m_prod <= '0;
    end else if (m_ready) begin
      if (start) begin
        m_ready <= 0; m_busy <= 1;
        m_rem   <= busy_cycles(is_signed, b);
        m_pend  <= gold(is_signed, a, b);
      end
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 0; m_done <= 1; m_prod <= m_pend;
      end
    end else if (m_done) begin
      m_done <= 0; m_ready <= 1;
    end
  always @(negedge clock)
    if (mon_en) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("product", 32'(product), 32'(m_prod));
    end
  // called at the negedge of the acceptance cycle; returns at the negedge of the first ready cycle
  task automatic wait_done(input logic [2*W-1:0] exp, input int exp_cyc);
    int c;
    @(negedge clock);
    c = 1;
    start = 0;
    a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
    while (!done && c < 40) begin
      @(negedge clock);
      c++;
    end
    chk("done_cycle", 32'(c), 32'(exp_cyc));
    chk("result", 32'(product), 32'(exp));
    @(negedge clock);
  endtask
  task automatic run(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [2*W-1:0] exp, input int exp_cyc);
    is_signed = s; a = x; b = y; start = 1;
    wait_done(exp, exp_cyc);
  endtask
  initial begin
    logic s;
    logic [W-1:0] x, y;
    reset_n = 0; start = 0; is_signed = 0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    mon_en = 1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_product", 32'(product), 32'd0);
    reset_n = 1;
    @(negedge clock);
    run(0, 8'hFF, 8'hFF, 16'hFE01, 10);
    run(1, 8'h80, 8'h80, 16'h4000, 10);
    run(1, 8'hFF, 8'h7F, 16'hFF81, 10);
    run(0, 8'hFF, 8'h02, 16'h01FE, lit(5, 10));
    run(1, 8'hFF, 8'h02, 16'hFFFE, lit(5, 10));
    run(0, 8'h5A, 8'h00, 16'h0000, lit(2, 10));
    run(1, 8'h80, 8'h7F, 16'hC080, 10);
    // start held high: pulses during CALC/DONE are ignored, next op taken in the first ready cycle
    is_signed = 0; a = 8'h03; b = 8'h55; start = 1;
    for (int i = 1; i <= W + 2; i++) begin
      @(negedge clock);
      a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
    end
    @(negedge clock);
    chk("hold_ready", 32'(ready), 32'd1);
    chk("hold_prod", 32'(product), 32'h00FF);
    is_signed = 0; a = 8'h07; b = 8'h09;
    wait_done(16'h003F, busy_cycles(0, 8'h09) + 1);
    // reset in cycle 5 of an operation
    is_signed = 0; a = 8'h03; b = 8'h04; start = 1;
    @(negedge clock);
    start = 0;
    repeat (4) @(negedge clock);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 0;
    @(negedge clock);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_prod", 32'(product), 32'd0);
    reset_n = 1;
    run(0, 8'h03, 8'h04, 16'h000C, lit(6, 10));
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      x = W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? W'($signed(4'($urandom))) : W'($urandom);
      run(s, x, y, gold(s, x, y), busy_cycles(s, y) + 1);
    end
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
